// File: rtl/wb_initiator_if.sv
// Wishbone classic bus bundle between the initiator and a single target.
interface wb_initiator_if;
   logic [29:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;

   modport master (
      output adr, dat_w, sel, cyc, stb, we, cti, bte,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, dat_w, sel, cyc, stb, we, cti, bte,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: accepts one command, runs one bus
// cycle with an optional timeout, and holds the response until it is consumed.
module wb_initiator #(
   parameter int TIMEOUT = 255
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [29:0]   cmd_adr,
   input  logic [31:0]   cmd_dat,
   input  logic [3:0]    cmd_sel,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_dat,
   output logic [1:0]    rsp_status,
   wb_initiator_if.master wb
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_BUS_ERR = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

   // A TIMEOUT of 0 still needs a legal 1-bit counter even though it never counts.
   localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic          cyc_q;
   logic          we_q;
   logic [29:0]   adr_q;
   logic [31:0]   dat_q;
   logic [3:0]    sel_q;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign cmd_ready = (state == ST_IDLE) & sys_rst_n;

   // stb shares the cyc register so the two can never diverge.
   assign wb.cyc   = cyc_q;
   assign wb.stb   = cyc_q;
   assign wb.we    = we_q;
   assign wb.adr   = adr_q;
   assign wb.dat_w = dat_q;
   assign wb.sel   = sel_q;
   assign wb.cti   = 3'b000;
   assign wb.bte   = 2'b00;

   // The counter holds the number of BUS cycles already elapsed before this edge.
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         rsp_valid  <= 1'b0;
         rsp_dat    <= '0;
         rsp_status <= STATUS_OK;
         tmo_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  adr_q   <= cmd_adr;
                  dat_q   <= cmd_dat;
                  sel_q   <= cmd_sel;
                  we_q    <= cmd_we;
                  cyc_q   <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= ST_BUS;
               end
            end
            ST_BUS: begin
               // Error beats ack, and either beats a timeout landing on the same edge.
               if (wb.err || wb.ack || tmo_hit) begin
                  cyc_q     <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
                  if (wb.err) begin
                     rsp_status <= STATUS_BUS_ERR;
                     rsp_dat    <= '0;
                  end else if (wb.ack) begin
                     rsp_status <= STATUS_OK;
                     rsp_dat    <= we_q ? 32'h0 : wb.dat_r;
                  end else begin
                     rsp_status <= STATUS_TIMEOUT;
                     rsp_dat    <= '0;
                  end
               end else if (TIMEOUT != 0) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cyc_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with a registered-ack memory target model.
module tb_wb_initiator;

   localparam logic [1:0] MODE_ACK    = 2'd0;
   localparam logic [1:0] MODE_ACKERR = 2'd1;
   localparam logic [1:0] MODE_SILENT = 2'd2;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [29:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic [1:0]  rsp_status;

   logic [1:0]  tgt_mode;
   logic        tgt_ack;
   logic        tgt_err;
   logic [31:0] tgt_dat;
   logic        force_ack;
   logic [31:0] mem [0:63];

   int errors;
   int checks;
   int cyc_cnt;
   logic hold_ok;

   wb_initiator_if bus ();

   assign bus.ack   = tgt_ack | force_ack;
   assign bus.err   = tgt_err;
   assign bus.dat_r = tgt_dat;

   wb_initiator #(.TIMEOUT(4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_dat    (cmd_dat),
      .cmd_sel    (cmd_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_dat    (rsp_dat),
      .rsp_status (rsp_status),
      .wb         (bus.master)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Target answers one cycle after it first sees a strobe, then drops its reply.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tgt_ack <= 1'b0;
         tgt_err <= 1'b0;
         tgt_dat <= '0;
      end else begin
         tgt_ack <= 1'b0;
         tgt_err <= 1'b0;
         if (bus.cyc && bus.stb && !tgt_ack && !tgt_err) begin
            if (tgt_mode == MODE_ACK) begin
               tgt_ack <= 1'b1;
               if (bus.we) begin
                  for (int b = 0; b < 4; b++)
                     if (bus.sel[b]) mem[bus.adr[5:0]][8*b +: 8] <= bus.dat_w[8*b +: 8];
               end else begin
                  tgt_dat <= mem[bus.adr[5:0]];
               end
            end else if (tgt_mode == MODE_ACKERR) begin
               tgt_ack <= 1'b1;
               tgt_err <= 1'b1;
               tgt_dat <= mem[bus.adr[5:0]];
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      @(negedge sys_clk);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready === 1'b1) break;
         @(negedge sys_clk);
      end
      checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic waitResp(input string tag, output int n);
      int   cnt;
      logic stb_ok;
      cnt    = 0;
      stb_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         if (bus.stb !== bus.cyc) stb_ok = 1'b0;
         if (bus.cyc === 1'b1) cnt++;
         if (rsp_valid === 1'b1) break;
      end
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_stb_eq_cyc"}, 32'(stb_ok), 32'd1);
      checkOutput({tag, "_cyc_dropped"}, 32'(bus.cyc), 32'd0);
      checkOutput({tag, "_no_bypass"}, 32'(cmd_ready), 32'd0);
      n = cnt;
   endtask

   task automatic takeResp(input string tag);
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      rsp_ready = 1'b0;
      checkOutput({tag, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      sys_rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b0;
      force_ack = 1'b0;
      tgt_mode  = MODE_ACK;

      // Reset state
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("rst_cyc", 32'(bus.cyc), 32'd0);
      checkOutput("rst_stb", 32'(bus.stb), 32'd0);
      checkOutput("rst_we", 32'(bus.we), 32'd0);
      checkOutput("rst_adr", 32'(bus.adr), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_status", 32'(rsp_status), 32'd0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);

      // Full-word write with a one-cycle target latency
      applyStimulus(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
      checkOutput("wr_cyc", 32'(bus.cyc), 32'd1);
      checkOutput("wr_adr", 32'(bus.adr), 32'h10);
      checkOutput("wr_dat_w", bus.dat_w, 32'hDEADBEEF);
      checkOutput("wr_sel", 32'(bus.sel), 32'hF);
      checkOutput("wr_we", 32'(bus.we), 32'd1);
      checkOutput("wr_cti_bte", 32'({bus.cti, bus.bte}), 32'd0);
      waitResp("wr1", cyc_cnt);
      checkOutput("wr1_cyc_cycles", 32'(cyc_cnt), 32'd2);
      checkOutput("wr1_status", 32'(rsp_status), 32'd0);
      checkOutput("wr1_rsp_dat", rsp_dat, 32'h0);
      takeResp("wr1");

      applyStimulus(1'b0, 30'h10, 32'h0, 4'hF);
      waitResp("rd1", cyc_cnt);
      checkOutput("rd1_status", 32'(rsp_status), 32'd0);
      checkOutput("rd1_rsp_dat", rsp_dat, 32'hDEADBEEF);
      takeResp("rd1");

      // Partial byte-select write over an all-ones word
      applyStimulus(1'b1, 30'h20, 32'hFFFFFFFF, 4'hF);
      waitResp("wr2", cyc_cnt);
      takeResp("wr2");
      applyStimulus(1'b1, 30'h20, 32'h12345678, 4'h3);
      waitResp("wr3", cyc_cnt);
      takeResp("wr3");
      applyStimulus(1'b0, 30'h20, 32'h0, 4'hF);
      waitResp("rd2", cyc_cnt);
      checkOutput("rd2_status", 32'(rsp_status), 32'd0);
      checkOutput("rd2_rsp_dat", rsp_dat, 32'hFFFF5678);
      takeResp("rd2");

      // Simultaneous ack and err on a read whose target data is non-zero
      tgt_mode = MODE_ACKERR;
      applyStimulus(1'b0, 30'h10, 32'h0, 4'hF);
      waitResp("err", cyc_cnt);
      checkOutput("err_cyc_cycles", 32'(cyc_cnt), 32'd2);
      checkOutput("err_status", 32'(rsp_status), 32'd1);
      checkOutput("err_rsp_dat", rsp_dat, 32'h0);
      takeResp("err");

      // Silent target hits the timeout, then the response is back-pressured
      tgt_mode = MODE_SILENT;
      applyStimulus(1'b0, 30'h10, 32'h0, 4'hF);
      waitResp("tmo", cyc_cnt);
      checkOutput("tmo_cyc_cycles", 32'(cyc_cnt), 32'd4);
      checkOutput("tmo_status", 32'(rsp_status), 32'd2);
      checkOutput("tmo_rsp_dat", rsp_dat, 32'h0);
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         force_ack = (i == 2);
         if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_status !== 2'b10 || cmd_ready !== 1'b0)
            hold_ok = 1'b0;
      end
      force_ack = 1'b0;
      checkOutput("hold_stable", 32'(hold_ok), 32'd1);
      takeResp("tmo");
      force_ack = 1'b1;
      @(negedge sys_clk);
      force_ack = 1'b0;
      @(negedge sys_clk);
      checkOutput("late_ack_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("late_ack_cyc", 32'(bus.cyc), 32'd0);

      // Asynchronous reset in the middle of a bus cycle
      applyStimulus(1'b1, 30'h30, 32'h55AA55AA, 4'hF);
      @(negedge sys_clk);
      checkOutput("mid_bus_cyc", 32'(bus.cyc), 32'd1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("arst_cyc", 32'(bus.cyc), 32'd0);
      checkOutput("arst_stb", 32'(bus.stb), 32'd0);
      checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("arst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tgt_mode  = MODE_ACK;
      repeat (2) @(negedge sys_clk);
      checkOutput("post_rst_rsp", 32'(rsp_valid), 32'd0);
      applyStimulus(1'b1, 30'h30, 32'hCAFEF00D, 4'hF);
      waitResp("wr4", cyc_cnt);
      checkOutput("wr4_cyc_cycles", 32'(cyc_cnt), 32'd2);
      checkOutput("wr4_status", 32'(rsp_status), 32'd0);
      takeResp("wr4");
      applyStimulus(1'b0, 30'h30, 32'h0, 4'hF);
      waitResp("rd4", cyc_cnt);
      checkOutput("rd4_rsp_dat", rsp_dat, 32'hCAFEF00D);
      takeResp("rd4");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
